// File: rtl/typer_pkg.sv
// Shared types and constants for the typer write scheduler.
package typer_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RECOVER   = 2'd3
    } state_t;

    // Field MSBs of one 24-bit requester word: {row, col, char}
    localparam int ROW_MSB = 23;
    localparam int COL_MSB = 15;
    localparam int CHR_MSB = 7;

    // 640x480 with an 8x16 font
    localparam int         DEF_ROWS       = 30;
    localparam int         DEF_COLS       = 80;
    localparam logic [7:0] DEF_CLEAR_CHAR = 8'h20;

    // One character write as presented to typer_logic
    typedef struct packed {
        logic [7:0] row;
        logic [7:0] col;
        logic [7:0] chr;
    } cell_wr_t;

    // Split a requester word into its fields
    function automatic cell_wr_t unpack_req(input logic [23:0] d);
        cell_wr_t c;
        c.row = d[ROW_MSB -: 8];
        c.col = d[COL_MSB -: 8];
        c.chr = d[CHR_MSB -: 8];
        return c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer and wraps; the
// pointer moves one past the served index when 'advance' is strobed.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             iVGA_CLK,
    input  logic             iRST_n,
    input  logic [N_REQ-1:0] valid,
    input  logic             advance,
    input  logic [IW-1:0]    adv_idx,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    grant_idx,
    output logic             any_valid
);

    logic [IW-1:0] ptr;

    // Scan offsets from highest to lowest so the smallest offset from ptr wins
    always_comb begin
        int idx;
        idx       = 0;
        grant_idx = '0;
        any_valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (valid[IW'(idx)]) begin
                any_valid = 1'b1;
                grant_idx = IW'(idx);
            end
        end
    end

    assign grant = any_valid ? (N_REQ'(1) << grant_idx) : '0;

    // Priority pointer: next search begins just after the requester served last
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (adv_idx == IW'(N_REQ - 1)) ? '0 : adv_idx + 1'b1;
        end
    end

endmodule

// File: rtl/typer_write_scheduler.sv
// Shares the typer_logic character-write port between N_REQ requesters and
// a clear-screen sequencer. Clear wins over requesters; requesters are
// served round-robin; each write is bounded by a timeout in both the wait
// for finished_saving_char and the wait for it to fall again.
module typer_write_scheduler
    import typer_pkg::*;
#(
    parameter int         N_REQ       = 2,
    parameter int         ROWS        = DEF_ROWS,
    parameter int         COLS        = DEF_COLS,
    parameter logic [7:0] CLEAR_CHAR  = DEF_CLEAR_CHAR,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic                iVGA_CLK,
    input  logic                iRST_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [24*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]    req_ack,
    input  logic                clear_req,
    output logic [7:0]          row_num,
    output logic [7:0]          col_num,
    output logic [7:0]          character_input,
    output logic                start_writing_character,
    input  logic                finished_saving_char,
    output logic                busy,
    output logic                timeout_err
);

    localparam int             IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int             CW       = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]     ROW_LAST = 8'(ROWS - 1);
    localparam logic [7:0]     COL_LAST = 8'(COLS - 1);

    state_t                  state, state_n;
    cell_wr_t                cell_q;
    logic                    start_q;
    logic [N_REQ-1:0]        ack_q;
    logic                    tmo_err_q;
    logic                    clear_pending;
    logic [7:0]              clr_row, clr_col;
    logic                    src_clear;
    logic [IW-1:0]           src_idx;
    logic [N_REQ-1:0]        src_oh;
    logic [CW-1:0]           tmo_cnt;
    logic [N_REQ-1:0][23:0]  req_arr;

    logic [N_REQ-1:0]        arb_grant;
    logic [IW-1:0]           arb_idx;
    logic                    arb_any;

    logic load_clr, load_req, issue, end_write, set_err, cnt_clr;
    logic clear_last, advance;

    assign req_arr    = req_data;
    assign clear_last = (clr_row == ROW_LAST) && (clr_col == COL_LAST);
    assign advance    = end_write && !src_clear;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .iVGA_CLK  (iVGA_CLK),
        .iRST_n    (iRST_n),
        .valid     (req_valid),
        .advance   (advance),
        .adv_idx   (src_idx),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_valid (arb_any)
    );

    // Next-state and per-cycle strobes
    always_comb begin
        state_n   = state;
        load_clr  = 1'b0;
        load_req  = 1'b0;
        issue     = 1'b0;
        end_write = 1'b0;
        set_err   = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clear_pending) begin
                    load_clr = 1'b1;
                    state_n  = ST_ISSUE;
                end else if (arb_any) begin
                    load_req = 1'b1;
                    state_n  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issue   = 1'b1;
                cnt_clr = 1'b1;
                state_n = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (finished_saving_char || tmo_cnt == TMO_LAST) begin
                    end_write = 1'b1;
                    set_err   = !finished_saving_char;
                    cnt_clr   = 1'b1;
                    state_n   = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (!finished_saving_char) begin
                    state_n = ST_IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    set_err = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) state <= ST_IDLE;
        else         state <= state_n;
    end

    // Cell registers and source tag are only loaded on a grant, so the
    // outputs stay stable for the whole write
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            cell_q    <= '0;
            src_clear <= 1'b0;
            src_idx   <= '0;
            src_oh    <= '0;
        end else if (load_clr) begin
            cell_q    <= '{row: clr_row, col: clr_col, chr: CLEAR_CHAR};
            src_clear <= 1'b1;
        end else if (load_req) begin
            cell_q    <= unpack_req(req_arr[arb_idx]);
            src_clear <= 1'b0;
            src_idx   <= arb_idx;
            src_oh    <= arb_grant;
        end
    end

    // Start strobe held from ISSUE until the write ends; ack pulses as it drops
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            start_q <= 1'b0;
            ack_q   <= '0;
        end else begin
            if (issue)          start_q <= 1'b1;
            else if (end_write) start_q <= 1'b0;
            ack_q <= advance ? src_oh : '0;
        end
    end

    // Clear walker: raster order, pending flag drops after the last cell
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            clear_pending <= 1'b0;
            clr_row       <= '0;
            clr_col       <= '0;
        end else if (end_write && src_clear) begin
            if (clear_last) begin
                clear_pending <= 1'b0;
                clr_row       <= '0;
                clr_col       <= '0;
            end else if (clr_col == COL_LAST) begin
                clr_col <= '0;
                clr_row <= clr_row + 8'd1;
            end else begin
                clr_col <= clr_col + 8'd1;
            end
        end else if (clear_req) begin
            clear_pending <= 1'b1;
        end
    end

    // Timeout counter runs in WAIT_DONE and RECOVER, restarted at each phase
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            tmo_cnt <= '0;
        end else if (cnt_clr) begin
            tmo_cnt <= '0;
        end else if (state == ST_WAIT_DONE || state == ST_RECOVER) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Sticky timeout flag
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n)      tmo_err_q <= 1'b0;
        else if (set_err) tmo_err_q <= 1'b1;
    end

    assign row_num                 = cell_q.row;
    assign col_num                 = cell_q.col;
    assign character_input         = cell_q.chr;
    assign start_writing_character = start_q;
    assign req_ack                 = ack_q;
    assign busy                    = (state != ST_IDLE);
    assign timeout_err             = tmo_err_q;

endmodule

// File: tb/tb_typer_write_scheduler.sv
// Randomized scoreboard bench for typer_write_scheduler with a typer_logic
// model, requester queues and a queue-level round-robin/clear reference.
module tb_typer_write_scheduler;

    localparam int N    = 2;
    localparam int ROWS = 2;
    localparam int COLS = 3;
    localparam int TMO  = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [47:0] req_data = '0;
    logic [1:0]  ack;
    logic        clear_req = 1'b0;
    logic [7:0]  row, col, chr;
    logic        start;
    logic        fin = 1'b0;
    logic        busy, terr;

    typer_write_scheduler #(
        .N_REQ(N), .ROWS(ROWS), .COLS(COLS), .CLEAR_CHAR(8'h20), .TIMEOUT_CYC(TMO)
    ) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ack(ack), .clear_req(clear_req), .row_num(row), .col_num(col),
        .character_input(chr), .start_writing_character(start),
        .finished_saving_char(fin), .busy(busy), .timeout_err(terr)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard and requester state
    logic [23:0] exp_wr[$];
    int          exp_ack[$];
    logic [23:0] rq0[$], rq1[$];
    int          m_ptr = 0;

    // typer_logic model knobs
    int lat = 3, hold = 1;
    bit never = 1'b0;
    int lat_cnt = 0, hold_cnt = 0;

    // Requester and typer_logic drivers, updated away from the active edge
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            fin = 1'b0; lat_cnt = 0; hold_cnt = 0;
        end else begin
            if (!start) lat_cnt = 0;
            if (fin) begin
                if (hold_cnt <= 1) fin = 1'b0;
                else hold_cnt--;
            end else if (start && !never) begin
                lat_cnt++;
                if (lat_cnt >= lat) begin fin = 1'b1; hold_cnt = hold; end
            end
            if (ack[0] && rq0.size() != 0) void'(rq0.pop_front());
            if (ack[1] && rq1.size() != 0) void'(rq1.pop_front());
        end
        req_valid = {rq1.size() != 0, rq0.size() != 0};
        req_data  = {(rq1.size() != 0) ? rq1[0] : 24'h0, (rq0.size() != 0) ? rq0[0] : 24'h0};
    end

    // Monitor: checks every write start and every ack against the scoreboard
    logic        prev_start = 1'b0;
    logic [23:0] cur_cell;
    int          sh_cnt = 0, last_width = 0;
    initial forever begin
        @(posedge clk); #1;
        if (!rst_n) begin
            prev_start = 1'b0; sh_cnt = 0;
        end else begin
            if (start && !prev_start) begin
                cur_cell = {row, col, chr};
                if (exp_wr.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_write: got %0h expected none at %0t", cur_cell, $time);
                end else begin
                    chk("write_cell", cur_cell, exp_wr.pop_front());
                end
                chk("fin_low_at_start", fin, 1'b0);
            end else if (start) begin
                chk("cell_stable", {row, col, chr}, cur_cell);
            end
            if (start) sh_cnt++;
            else if (prev_start) begin last_width = sh_cnt; sh_cnt = 0; end
            if (ack != 0) begin
                if (exp_ack.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_ack: got %0h expected none at %0t", ack, $time);
                end else begin
                    chk("ack_index", ack, 32'(1) << exp_ack.pop_front());
                end
                chk("ack_with_start_fall", {prev_start, start}, 2'b10);
            end
            prev_start = start;
        end
    end

    // Reference: all queues loaded at once are drained round-robin
    task automatic load_reqs(input int c0, input int c1);
        int cnt[2];
        logic [23:0] d0[$], d1[$];
        logic [23:0] v;
        int g;
        for (int j = 0; j < c0; j++) begin v = 24'($urandom); d0.push_back(v); rq0.push_back(v); end
        for (int j = 0; j < c1; j++) begin v = 24'($urandom); d1.push_back(v); rq1.push_back(v); end
        cnt[0] = c0; cnt[1] = c1;
        while (cnt[0] + cnt[1] > 0) begin
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && cnt[(m_ptr + k) % N] > 0) g = (m_ptr + k) % N;
            v = (g == 0) ? d0.pop_front() : d1.pop_front();
            exp_wr.push_back(v);
            exp_ack.push_back(g);
            cnt[g]--;
            m_ptr = (g + 1) % N;
        end
    endtask

    task automatic push_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                exp_wr.push_back({8'(r), 8'(c), 8'h20});
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear_req = 1'b1;
        @(negedge clk); clear_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int quiet = 0, k = 0;
        while (quiet < 3 && k < budget) begin
            @(negedge clk); #1; k++;
            if (!busy && rq0.size() == 0 && rq1.size() == 0 && exp_wr.size() == 0 && exp_ack.size() == 0)
                quiet++;
            else
                quiet = 0;
        end
        chk({tag, "_drained"}, 32'(quiet >= 3), 1);
        if (quiet < 3) begin
            rq0.delete(); rq1.delete(); exp_wr.delete(); exp_ack.delete();
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_row"}, row, 0);
        chk({tag, "_col"}, col, 0);
        chk({tag, "_chr"}, chr, 0);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_terr"}, terr, 0);
    endtask

    initial begin
        int t_v, t_s, k;
        // Reset state
        repeat (3) @(posedge clk);
        #1 chk_outputs_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single request, fixed latency to start
        lat = 4; hold = 1;
        rq0.push_back({8'd3, 8'd5, 8'h41});
        exp_wr.push_back({8'd3, 8'd5, 8'h41});
        exp_ack.push_back(0);
        m_ptr = 1;
        t_v = -1; t_s = -1; k = 0;
        while (t_s < 0 && k < 20) begin
            @(negedge clk); #1;
            if (t_v < 0 && req_valid[0]) t_v = k;
            if (t_s < 0 && start) t_s = k;
            k++;
        end
        chk("single_latency", 32'(t_s - t_v), 2);
        wait_idle("single", 100);
        chk("single_busy_low", busy, 0);

        // 2: both requesters loaded, then randomized rounds
        lat = 3; hold = 1;
        @(negedge clk); load_reqs(4, 4);
        wait_idle("alternate", 400);
        for (int r = 0; r < 6; r++) begin
            lat = $urandom_range(1, 4); hold = $urandom_range(1, 3);
            @(negedge clk); load_reqs($urandom_range(0, 4), $urandom_range(0, 4));
            wait_idle("random", 400);
        end

        // 3: clear walks every cell before the waiting requester; repeat pulse ignored
        lat = 2; hold = 1;
        push_clear();
        pulse_clear();
        repeat (3) @(negedge clk);
        load_reqs(1, 0);
        repeat (8) @(negedge clk);
        pulse_clear();
        wait_idle("clear", 600);
        chk("terr_before_timeout", terr, 0);

        // 4: typer never finishes -> timeout, ack, sticky error, service continues
        never = 1'b1;
        @(negedge clk); load_reqs(1, 0);
        k = 0;
        while (exp_ack.size() != 0 && k < 5000) begin @(negedge clk); #1; k++; end
        chk("timeout_reached", 32'(exp_ack.size()), 0);
        chk("timeout_width", last_width, TMO);
        chk("timeout_err_set", terr, 1);
        never = 1'b0; lat = 2;
        wait_idle("timeout_ack", 100);
        @(negedge clk); load_reqs(0, 1);
        wait_idle("after_timeout", 200);
        chk("timeout_err_sticky", terr, 1);

        // 5: reset during WAIT_DONE with a clear pending
        never = 1'b1;
        @(negedge clk); load_reqs(1, 0);
        k = 0;
        while (!start && k < 20) begin @(negedge clk); #1; k++; end
        chk("rst_write_started", start, 1);
        repeat (2) @(negedge clk);
        pulse_clear();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("mid_reset");
        rq0.delete(); rq1.delete(); exp_wr.delete(); exp_ack.delete();
        m_ptr = 0; never = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        #1 chk("post_reset_busy", busy, 0);
        chk("post_reset_terr", terr, 0);

        // 6: finished held high for several cycles holds off the next write
        lat = 1; hold = 5;
        @(negedge clk); load_reqs(2, 2);
        wait_idle("hold_high", 400);

        // Mixed tail: clear followed by random traffic
        lat = $urandom_range(1, 3); hold = $urandom_range(1, 4);
        push_clear();
        pulse_clear();
        @(negedge clk); load_reqs($urandom_range(1, 3), $urandom_range(1, 3));
        wait_idle("tail", 800);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

endmodule
